// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nand3_bist_ctrl.sv
// gf180mcu_fd_sc_mcu7t5v0__nand3_bist_ctrl: exhaustive BIST sweep of a NAND3 cell with mismatch statistics
module gf180mcu_fd_sc_mcu7t5v0__nand3_bist_ctrl #(
   parameter int SETTLE = 2,
   parameter int SWEEPS = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic       ZN,
   output logic       A1,
   output logic       A2,
   output logic       A3,
   output logic       BUSY,
   output logic       DONE,
   output logic       PASS,
   output logic [3:0] ERR_CNT,
   output logic [2:0] FIRST_ERR
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [3:0] CNT_INIT   = 4'(SETTLE - 1);
   localparam logic [7:0] SWEEP_LAST = 8'(SWEEPS - 1);
   logic [1:0] state;
   logic [2:0] v;
   logic [3:0] cnt;
   logic [7:0] sweep;
   logic       mismatch;
   logic [3:0] err_next;
   assign {A3, A2, A1} = v;
   assign mismatch = ZN != ~&v;
   assign err_next = (mismatch && ERR_CNT != 4'd15) ? ERR_CNT + 4'd1 : ERR_CNT;
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         state     <= S_IDLE;
         v         <= '0;
         cnt       <= '0;
         sweep     <= '0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         PASS      <= 1'b0;
         ERR_CNT   <= '0;
         FIRST_ERR <= '0;
      end else
         case (state)
            S_IDLE:
               if (START) begin
                  state     <= S_SETTLE;
                  v         <= '0;
                  sweep     <= '0;
                  cnt       <= CNT_INIT;
                  BUSY      <= 1'b1;
                  DONE      <= 1'b0;
                  PASS      <= 1'b0;
                  ERR_CNT   <= '0;
                  FIRST_ERR <= '0;
               end
            S_SETTLE:
               if (cnt == 4'd0) state <= S_SAMPLE;
               else cnt <= cnt - 4'd1;
            S_SAMPLE: begin
               ERR_CNT <= err_next;
               if (mismatch && ERR_CNT == 4'd0) FIRST_ERR <= v;
               // v wraps 7 -> 0 both between sweeps and at run end
               v <= v + 3'd1;
               if (v != 3'd7 || sweep != SWEEP_LAST) begin
                  cnt   <= CNT_INIT;
                  state <= S_SETTLE;
                  if (v == 3'd7) sweep <= sweep + 8'd1;
               end else begin
                  state <= S_IDLE;
                  BUSY  <= 1'b0;
                  DONE  <= 1'b1;
                  PASS  <= err_next == 4'd0;
               end
            end
            default: state <= S_IDLE;
         endcase
endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__nand3_bist_ctrl.md
# gf180mcu_fd_sc_mcu7t5v0__nand3_bist_ctrl

Built-in self-test controller for the 3-input NAND cell. It sits directly around the cell: upstream it drives the cell's A1/A2/A3 inputs with an exhaustive 8-vector sweep, and downstream it samples the cell's ZN output. Each sample is compared against the expected NAND3 value. Mismatch statistics and a pass/fail verdict are reported to the test access logic.

## Interface
Parameters:
- SETTLE, default 2: cycles each vector is held before ZN is sampled; legal 1..15.
- SWEEPS, default 1: full 8-vector sweeps per run; legal 1..255.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  reset, asynchronous, active-high.
- START  input  1  run request; sampled only in IDLE.
- ZN  input  1  output of the cell under test.
- A1  output  1  cell input, vector bit 0.
- A2  output  1  cell input, vector bit 1.
- A3  output  1  cell input, vector bit 2.
- BUSY  output  1  run in progress.
- DONE  output  1  run complete; level, held until next accepted START or RST.
- PASS  output  1  valid while DONE=1; 1 when no mismatch occurred.
- ERR_CNT  output  4  mismatch count, saturating at 15.
- FIRST_ERR  output  3  vector {A3,A2,A1} of first mismatch; 0 if none.

## Operation
- All outputs are registered.
- Reset values: A1=A2=A3=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FIRST_ERR=0, state IDLE.
- Internal state:
  - 3-bit vector v; A1=v[0], A2=v[1], A3=v[2].
  - settle counter, 4 bits.
  - sweep counter, 8 bits.
- Expected ZN = ~(v[0]&v[1]&v[2]): 1 for v=0..6, 0 for v=7.
- FSM states: IDLE, SETTLE, SAMPLE.
- IDLE:
  - START=1 → SETTLE.
  - On that transition: v=0, sweep=0, cnt=SETTLE-1, BUSY=1, DONE=0, PASS=0, ERR_CNT=0, FIRST_ERR=0.
  - START=0 → stay in IDLE; outputs hold.
- SETTLE:
  - cnt==0 → SAMPLE.
  - Otherwise cnt decrements.
- SAMPLE (one cycle), compare ZN against expected:
  - On mismatch, ERR_CNT increments unless it is already 15.
  - On mismatch with ERR_CNT==0 beforehand, FIRST_ERR=v.
- SAMPLE next-state:
  - v<7: v=v+1, cnt=SETTLE-1, go to SETTLE.
  - v==7 and sweep<SWEEPS-1: v=0, sweep=sweep+1, cnt=SETTLE-1, go to SETTLE.
  - v==7 and sweep==SWEEPS-1: v=0, BUSY=0, DONE=1, go to IDLE. PASS=1 if the final ERR_CNT (including this last compare) is 0.
- START while BUSY=1 is ignored.
- START in IDLE with DONE=1 clears the previous results and begins a new run.
- RST asserted at any time, including mid-run, forces reset values immediately. No partial results survive.

## Timing
- START is accepted on rising edge k; BUSY=1 and v=0 are visible after edge k.
- Each vector is held for exactly SETTLE+1 cycles. ZN is sampled on the last edge of that window, so the cell path has SETTLE+1 cycles to settle.
- A vector change and the compare of the previous vector occur on the same edge.
- DONE rises and BUSY falls after edge k + 8·SWEEPS·(SETTLE+1).
- ERR_CNT, PASS and FIRST_ERR are stable from that edge onward.
- Back-to-back runs: START may be accepted on the first edge with DONE=1, giving a minimum of 1 idle cycle between runs.
- ZN is treated as synchronous to CLK. The block provides no synchronizer.

## Test plan
- Reset check: assert RST mid-cycle with no clock → all outputs 0, state IDLE. Release RST with START=0 for 10 cycles → outputs unchanged.
- Ideal NAND3 model on ZN, SETTLE=2, SWEEPS=1; pulse START → A sequence is 000,001,…,111, each held 3 cycles. DONE=1 at edge k+24 with PASS=1, ERR_CNT=0, FIRST_ERR=0.
- ZN stuck at 1 → only v=7 mismatches. Result: ERR_CNT=1, FIRST_ERR=3'b111, PASS=0, DONE at k+24.
- ZN stuck at 0, SWEEPS=3 → 21 mismatches. Result: ERR_CNT saturates at 15, FIRST_ERR=0, PASS=0, DONE at k+72.
- Run interference with ideal ZN:
  - Re-pulse START at cycle 5 → ignored; DONE still at k+24.
  - Assert RST at cycle 10 → immediate reset values.
  - New START → clean run with DONE 24 cycles later and PASS=1.
- SETTLE=1, ideal ZN → each vector held 2 cycles, DONE at k+16, PASS=1. A START on the DONE cycle restarts with DONE cleared one edge later.
